// File: rtl/imem_responder.sv
// Instruction-memory responder: byte array with backdoor load port, answering word
// fetches after LATENCY cycles with a one-cycle imem_drdy pulse.
module imem_responder #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic        imem_read,
    output logic        imem_drdy,
    output logic [31:0] imem_rdata,
    output logic        imem_fault,
    output logic        busy,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [7:0]  load_data
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        capture;
    logic [31:0] cap_addr;
    logic [AW-1:0] idx;
    logic        cap_fault;
    logic [31:0] cap_word;

    logic [7:0]  mem [DEPTH_BYTES];

    // Upper backdoor address bits are ignored: writes wrap modulo the array size.
    logic        unused_load_addr;
    assign unused_load_addr = ^load_addr[31:AW];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        capture  = 1'b0;
        cap_addr = addr_q;
        unique case (state_q)
            StIdle, StResp: begin
                state_d = StIdle;
                if (imem_read) begin
                    addr_d = imem_addr;
                    cnt_d  = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d  = StResp;
                        capture  = 1'b1;
                        cap_addr = imem_addr;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array is sampled combinationally, so a backdoor write on the capture edge is not seen.
    always_comb begin
        idx       = cap_addr[AW-1:0];
        cap_fault = (cap_addr[1:0] != 2'b00) || (cap_addr > 32'(DEPTH_BYTES - 4));
        cap_word  = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        if (capture) begin
            fault_d = cap_fault;
            rdata_d = cap_fault ? 32'h0 : cap_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign imem_drdy  = (state_q == StResp);
    assign busy       = (state_q == StWait);
    assign imem_rdata = rdata_q;
    assign imem_fault = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1, one at LATENCY=3,
// sharing clock, reset and the backdoor load bus.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [31:0] load_addr;
    logic [7:0]  load_data;

    logic [31:0] addr1, addr3;
    logic        rd1, rd3;
    logic        drdy1, drdy3, fault1, fault3, busy1, busy3;
    logic [31:0] rdata1, rdata3;

    int n_checks = 0;
    int n_errors = 0;

    imem_responder #(.DEPTH_BYTES(4096), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .imem_addr(addr1), .imem_read(rd1),
        .imem_drdy(drdy1), .imem_rdata(rdata1), .imem_fault(fault1), .busy(busy1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH_BYTES(4096), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .imem_addr(addr3), .imem_read(rd3),
        .imem_drdy(drdy3), .imem_rdata(rdata3), .imem_fault(fault3), .busy(busy3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            load_byte(a + 32'(i), w[8*i +: 8]);
        end
    endtask

    initial begin
        rst = 1'b1;
        load_en = 1'b0; load_addr = 32'h0; load_data = 8'h0;
        rd1 = 1'b0; rd3 = 1'b0; addr1 = 32'h0; addr3 = 32'h0;
        step();
        step();
        check_eq("rst_drdy1", {31'h0, drdy1}, 32'h0);
        check_eq("rst_busy1", {31'h0, busy1}, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_fault1", {31'h0, fault1}, 32'h0);
        check_eq("rst_drdy3", {31'h0, drdy3}, 32'h0);
        check_eq("rst_busy3", {31'h0, busy3}, 32'h0);
        check_eq("rst_rdata3", rdata3, 32'h0);
        rst = 1'b0;

        load_byte(32'h0, 8'h13);
        load_byte(32'h1, 8'h05);
        load_byte(32'h2, 8'h10);
        load_byte(32'h3, 8'h00);
        load_word(32'h4, 32'h0020_0593);
        load_word(32'h8, 32'h00b5_0633);
        load_word(32'hFFC, 32'h1234_5678);

        // Basic fetch, LATENCY=1
        rd1 = 1'b1; addr1 = 32'h0;
        step();
        rd1 = 1'b0;
        check_eq("basic_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("basic_rdata", rdata1, 32'h0010_0513);
        check_eq("basic_fault", {31'h0, fault1}, 32'h0);
        step();
        check_eq("basic_drdy_off", {31'h0, drdy1}, 32'h0);

        // Streaming, LATENCY=1
        rd1 = 1'b1; addr1 = 32'h0;
        step();
        check_eq("strm0_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("strm0_rdata", rdata1, 32'h0010_0513);
        check_eq("strm0_busy", {31'h0, busy1}, 32'h0);
        addr1 = 32'h4;
        step();
        check_eq("strm1_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("strm1_rdata", rdata1, 32'h0020_0593);
        check_eq("strm1_busy", {31'h0, busy1}, 32'h0);
        addr1 = 32'h8;
        step();
        rd1 = 1'b0;
        check_eq("strm2_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("strm2_rdata", rdata1, 32'h00b5_0633);
        check_eq("strm2_busy", {31'h0, busy1}, 32'h0);
        step();
        check_eq("strm_end_drdy", {31'h0, drdy1}, 32'h0);
        check_eq("strm_hold_rdata", rdata1, 32'h00b5_0633);

        // Latency, LATENCY=3; read during WAIT is ignored
        rd3 = 1'b1; addr3 = 32'h4;
        step();
        addr3 = 32'h8;
        check_eq("lat_n_busy", {31'h0, busy3}, 32'h1);
        check_eq("lat_n_drdy", {31'h0, drdy3}, 32'h0);
        step();
        rd3 = 1'b0;
        check_eq("lat_n1_busy", {31'h0, busy3}, 32'h1);
        check_eq("lat_n1_drdy", {31'h0, drdy3}, 32'h0);
        step();
        check_eq("lat_n2_drdy", {31'h0, drdy3}, 32'h1);
        check_eq("lat_n2_rdata", rdata3, 32'h0020_0593);
        check_eq("lat_n2_busy", {31'h0, busy3}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("lat_no_second", {31'h0, drdy3}, 32'h0);
        end

        // Faults
        rd1 = 1'b1; addr1 = 32'h2;
        step();
        rd1 = 1'b0;
        check_eq("mis_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("mis_fault", {31'h0, fault1}, 32'h1);
        check_eq("mis_rdata", rdata1, 32'h0);
        step();
        check_eq("mis_hold_fault", {31'h0, fault1}, 32'h1);
        rd1 = 1'b1; addr1 = 32'h1000;
        step();
        rd1 = 1'b0;
        check_eq("oor_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("oor_fault", {31'h0, fault1}, 32'h1);
        check_eq("oor_rdata", rdata1, 32'h0);
        step();
        rd1 = 1'b1; addr1 = 32'hFFC;
        step();
        rd1 = 1'b0;
        check_eq("top_drdy", {31'h0, drdy1}, 32'h1);
        check_eq("top_fault", {31'h0, fault1}, 32'h0);
        check_eq("top_rdata", rdata1, 32'h1234_5678);
        step();

        // Load/read ordering, LATENCY=3: write one edge before the RESP edge is seen
        rd3 = 1'b1; addr3 = 32'h0;
        step();
        rd3 = 1'b0;
        load_byte(32'h0, 8'hFF);
        step();
        check_eq("ord_early_drdy", {31'h0, drdy3}, 32'h1);
        check_eq("ord_early_rdata", rdata3, 32'h0010_05FF);
        load_byte(32'h0, 8'h13);
        // Write on the RESP edge itself is not seen
        rd3 = 1'b1; addr3 = 32'h0;
        step();
        rd3 = 1'b0;
        step();
        load_byte(32'h0, 8'hFF);
        check_eq("ord_same_drdy", {31'h0, drdy3}, 32'h1);
        check_eq("ord_same_rdata", rdata3, 32'h0010_0513);
        load_byte(32'h0, 8'h13);

        // Reset mid-WAIT drops the request; a request in the reset cycle is refused
        rd3 = 1'b1; addr3 = 32'h4;
        step();
        check_eq("rst_mid_busy_pre", {31'h0, busy3}, 32'h1);
        rst = 1'b1; addr3 = 32'h8;
        step();
        rst = 1'b0; rd3 = 1'b0;
        check_eq("rst_mid_drdy", {31'h0, drdy3}, 32'h0);
        check_eq("rst_mid_busy", {31'h0, busy3}, 32'h0);
        check_eq("rst_mid_rdata", rdata3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rst_mid_no_drdy", {31'h0, drdy3 | busy3}, 32'h0);
        end
        rd3 = 1'b1; addr3 = 32'h0;
        step();
        rd3 = 1'b0;
        step();
        step();
        check_eq("post_rst_drdy", {31'h0, drdy3}, 32'h1);
        check_eq("post_rst_rdata", rdata3, 32'h0010_0513);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
